// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C transaction scheduler.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddrWait,
    StXfer,
    StAckWait,
    StStop,
    StDone
  } sched_state_t;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// One-hot round-robin arbiter. The search starts at the stored pointer, which
// advances to last grantee + 1 only when i_update is pulsed.
module i2c_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_update,
  input  logic [IDX_W-1:0]   i_last_idx,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [SUM_W-1:0]   w_sum;
  logic               w_found;

  // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
  always_comb begin
    w_rot   = NUM_REQ'({i_req, i_req} >> r_ptr);
    w_found = |w_rot;
    w_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= SUM_W'(NUM_REQ)) begin
      w_sum = w_sum - SUM_W'(NUM_REQ);
    end
    o_grant_idx = w_sum[IDX_W-1:0];
    o_grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = w_found && (o_grant_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (i_last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : i_last_idx + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_sched.sv
// Schedules write transactions from NUM_REQ requesters onto one I2C master.
// Optional watchdog: define I2C_SCHED_TIMEOUT_EN.
module i2c_txn_sched
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned MAX_LEN     = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1),
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                      i_scl_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_pop,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [NUM_REQ-1:0]        o_nack,
  output logic                      o_timeout,
  output logic                      o_m_start,
  output logic                      o_m_stop,
  output logic [ADDR_W-1:0]         o_m_cfg_address,
  output logic [DATA_W-1:0]         o_m_tx_data,
  output logic                      o_m_tx_valid,
  input  logic                      i_m_tx_ready,
  input  logic                      i_m_busy,
  input  logic                      i_m_ack_valid,
  input  logic                      i_m_ack
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LEN < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("i2c_txn_sched: parameter out of range");
  end

  sched_state_t       r_state, w_state_d;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_nack;

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [LEN_W-1:0]   w_len  [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [LEN_W-1:0]   w_sel_len;
  logic               w_len_ok;
  logic               w_load, w_pop, w_set_nack, w_done;
  logic               w_timeout, w_wd_active;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g] = i_req_addr[g*ADDR_W +: ADDR_W];
    assign w_len[g]  = i_req_len[g*LEN_W +: LEN_W];
    assign w_data[g] = i_req_data[g*DATA_W +: DATA_W];
  end

  i2c_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_clk      (i_scl_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req_valid),
    .i_update   (w_done),
    .i_last_idx (r_idx),
    .o_grant    (w_arb_grant),
    .o_grant_idx(w_arb_idx)
  );

  assign w_sel_len   = w_len[w_arb_idx];
  assign w_len_ok    = (w_sel_len != '0) && (w_sel_len <= LEN_W'(MAX_LEN));
  assign w_wd_active = (r_state == StAddrWait) || (r_state == StXfer) || (r_state == StAckWait);

`ifdef I2C_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_wd_cnt;

  always_ff @(posedge i_scl_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state != w_state_d) begin
      r_wd_cnt <= '0;
    end else if (w_wd_active) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = w_wd_active && (r_wd_cnt == CNT_W'(TIMEOUT_CYC));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_set_nack   = 1'b0;
    w_done       = 1'b0;
    o_m_start    = 1'b0;
    o_m_stop     = 1'b0;
    o_m_tx_valid = 1'b0;
    o_m_tx_data  = '0;
    unique case (r_state)
      StIdle: begin
        if (|i_req_valid && !i_m_busy) begin
          w_load    = 1'b1;
          w_state_d = w_len_ok ? StStart : StDone;
        end
      end
      StStart: begin
        o_m_start = 1'b1;
        w_state_d = StAddrWait;
      end
      StAddrWait: begin
        if (w_timeout) begin
          w_set_nack = 1'b1;
          w_state_d  = StStop;
        end else if (i_m_ack_valid) begin
          w_set_nack = i_m_ack;
          w_state_d  = i_m_ack ? StStop : StXfer;
        end
      end
      StXfer: begin
        o_m_tx_valid = 1'b1;
        o_m_tx_data  = w_data[r_idx];
        if (w_timeout) begin
          w_set_nack = 1'b1;
          w_state_d  = StStop;
        end else if (i_m_tx_ready) begin
          w_pop     = 1'b1;
          w_state_d = StAckWait;
        end
      end
      StAckWait: begin
        if (w_timeout) begin
          w_set_nack = 1'b1;
          w_state_d  = StStop;
        end else if (i_m_ack_valid) begin
          w_set_nack = i_m_ack;
          w_state_d  = (i_m_ack || r_remaining == '0) ? StStop : StXfer;
        end
      end
      StStop: begin
        o_m_stop = 1'b1;
        if (!i_m_busy) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_scl_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_nack      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_grant     <= w_arb_grant;
        r_idx       <= w_arb_idx;
        r_addr      <= w_addr[w_arb_idx];
        r_remaining <= w_sel_len;
        r_nack      <= !w_len_ok;
      end else begin
        if (w_pop) begin
          r_remaining <= r_remaining - 1'b1;
        end
        if (w_set_nack) begin
          r_nack <= 1'b1;
        end
        if (w_done) begin
          r_grant <= '0;
        end
      end
    end
  end

  assign o_grant         = r_grant;
  assign o_req_pop       = w_pop ? r_grant : '0;
  assign o_done          = w_done ? r_grant : '0;
  assign o_nack          = (w_done && r_nack) ? r_grant : '0;
  assign o_timeout       = w_timeout;
  assign o_m_cfg_address = r_addr;

endmodule

// File: doc/i2c_txn_sched.md
I2C_TXN_SCHED -- requirements
Module: i2c_txn_sched

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters, range 2..8.
REQ-002 Parameter MAX_LEN, default 4: maximum write bytes per transaction; LEN_W = $clog2(MAX_LEN+1).
REQ-003 Parameter TIMEOUT_CYC, default 64: watchdog limit in clocks, used only when I2C_SCHED_TIMEOUT_EN is defined.
REQ-004 scl_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester transaction request, held until done.
REQ-007 req_addr  in  NUM_REQ*7  per-requester 7-bit target address.
REQ-008 req_len  in  NUM_REQ*LEN_W  per-requester byte count.
REQ-009 req_data  in  NUM_REQ*8  per-requester next write byte.
REQ-010 req_pop  out  NUM_REQ  one-cycle pulse: grantee's current byte consumed.
REQ-011 grant  out  NUM_REQ  one-hot owner, held for the whole transaction.
REQ-012 done  out  NUM_REQ  one-cycle completion pulse.
REQ-013 nack  out  NUM_REQ  set with done when the transaction ended by NACK or timeout.
REQ-014 timeout  out  1  one-cycle pulse when the watchdog fires.
REQ-015 m_start, m_stop  out  1 each  commands to the I2C master FSM.
REQ-016 m_cfg_address  out  7  latched address of the grantee.
REQ-017 m_tx_data  out  8  byte driven to the master; m_tx_valid  out  1.
REQ-018 m_tx_ready, m_busy, m_ack_valid, m_ack  in  1 each  master status; m_ack=1 means NACK, sampled only when m_ack_valid=1.

Function
REQ-019 States: IDLE, START, ADDR_WAIT, XFER, ACK_WAIT, STOP, DONE.
REQ-020 IDLE: when any req_valid=1 and m_busy=0, the block grants the round-robin winner, latches its address and length, and enters START on the next edge.
REQ-021 Round-robin pointer: the search starts at last grantee+1, modulo NUM_REQ; the pointer updates only in DONE.
REQ-022 req_len=0 or req_len>MAX_LEN: granted, then DONE with nack=1 on the next cycle; no m_start is issued.
REQ-023 START: m_start=1 for exactly one cycle; next state is ADDR_WAIT.
REQ-024 ADDR_WAIT: on m_ack_valid, m_ack=0 -> XFER; m_ack=1 -> STOP with the nack flag set.
REQ-025 XFER: m_tx_data=req_data[grantee] and m_tx_valid=1; on m_tx_valid&&m_tx_ready, req_pop pulses, remaining decrements, and the state becomes ACK_WAIT.
REQ-026 ACK_WAIT: on m_ack_valid, m_ack=1 -> STOP with nack flagged; remaining=0 -> STOP; otherwise -> XFER.
REQ-027 STOP: m_stop is held at 1 until m_busy=0 is sampled, then DONE.
REQ-028 DONE: done[g]=1 and nack[g]=flag for one cycle; grant drops; the state returns to IDLE.
REQ-029 Deassertion of req_valid by the grantee mid-transaction is ignored; the transaction completes.
REQ-030 m_ack_valid outside ADDR_WAIT/ACK_WAIT is ignored.
REQ-031 Back-to-back operation: a new grant may occur in the cycle after DONE; there are no idle bubbles beyond that cycle.

Reset
REQ-032 While rst_n=0: state=IDLE; grant, done, nack, req_pop, timeout, m_start, m_stop, m_tx_valid = 0; m_cfg_address, m_tx_data = 0; RR pointer=0.
REQ-033 Reset mid-transaction aborts immediately with no done pulse; the master is reset by the same rst_n.

Configuration
REQ-034 With I2C_SCHED_TIMEOUT_EN defined: a counter clears on every state change and increments in ADDR_WAIT, XFER and ACK_WAIT; reaching TIMEOUT_CYC pulses timeout, sets the nack flag, and forces STOP.
REQ-035 Without I2C_SCHED_TIMEOUT_EN: no counter is built, timeout is tied 0, and those states wait indefinitely.

Structure
REQ-036 Package i2c_pkg holds the sched_state_t enum, ADDR_W=7, and DATA_W=8.
REQ-037 Sub-module i2c_rr_arbiter (NUM_REQ one-hot round-robin, pointer-update input) holds the grant logic.

Verification
REQ-038 Single request: req0 with addr 0x50, len 2, bytes 0xA5/0x3C, all ACKs -> one m_start, two req_pop, m_stop, done[0]=1, nack[0]=0.
REQ-039 Address NACK: m_ack=1 in ADDR_WAIT -> no m_tx_valid, m_stop, done[0]=1, nack[0]=1.
REQ-040 Fairness: req0 and req1 held continuously, len 1 each -> grants alternate 0,1,0,1 over four transactions.
REQ-041 Data NACK: len 3 with NACK on byte 2 -> exactly 2 req_pop, then STOP, nack=1.
REQ-042 Timeout (macro on, TIMEOUT_CYC=64): m_ack_valid withheld -> timeout pulse 64 cycles after ADDR_WAIT entry, then done with nack=1.
REQ-043 Reset asserted during XFER -> all outputs 0 asynchronously; a fresh request afterwards gets grant[0].
